// File: rtl/step_tracker_if.sv
// Bundle of the quadrature-style step inputs and the tracker status outputs.
// The tracker side uses the slave modport; the driving/observing side uses master.
interface step_tracker_if #(
  parameter int POS_W = 8
);
  logic                    A;
  logic                    B;
  logic                    clear;
  logic signed [POS_W-1:0] pos;
  logic                    step_up;
  logic                    step_dn;
  logic                    reversal;
  logic [1:0]              dir;
  logic                    err;
  logic [3:0]              err_cnt;

  modport master (
    output A, B, clear,
    input  pos, step_up, step_dn, reversal, dir, err, err_cnt
  );

  modport slave (
    input  A, B, clear,
    output pos, step_up, step_dn, reversal, dir, err, err_cnt
  );
endinterface

// File: rtl/step_tracker.sv
// Step tracker: watches the 2-bit up/down count {A,B}, classifies each sample
// against the previous one as hold/up/down/illegal, keeps a signed net position,
// a direction FSM with a sticky FAULT state, and a saturating illegal-step count.
module step_tracker #(
  parameter int POS_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  step_tracker_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    FAULT = 2'b11
  } state_e;

  // Difference s - prev (mod 4) encodes the step class directly.
  localparam logic [1:0] D_HOLD    = 2'd0;
  localparam logic [1:0] D_UP      = 2'd1;
  localparam logic [1:0] D_ILLEGAL = 2'd2;
  localparam logic [1:0] D_DOWN    = 2'd3;

  logic [1:0]              s;
  logic [1:0]              delta;

  logic [1:0]              prev_q, prev_d;
  logic                    armed_q, armed_d;
  state_e                  state_q, state_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    step_up_q, step_up_d;
  logic                    step_dn_q, step_dn_d;
  logic                    reversal_q, reversal_d;
  logic                    err_q, err_d;
  logic [3:0]              err_cnt_q, err_cnt_d;

  assign s     = {bus.A, bus.B};
  assign delta = s - prev_q;

  // Next-state logic: classify the current sample and update position/FSM/error state.
  always_comb begin
    prev_d     = s;              // prev always tracks the input, even in FAULT or on clear
    armed_d    = 1'b1;
    state_d    = state_q;
    pos_d      = pos_q;
    step_up_d  = 1'b0;
    step_dn_d  = 1'b0;
    reversal_d = 1'b0;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    // The first edge after reset only captures prev; no classification yet.
    if (armed_q) begin
      if (delta == D_ILLEGAL) begin
        state_d = FAULT;
        err_d   = 1'b1;
        if (err_cnt_q != 4'd15) begin
          err_cnt_d = err_cnt_q + 4'd1;
        end
      end else if (state_q != FAULT) begin
        if (delta == D_UP) begin
          step_up_d  = 1'b1;
          pos_d      = pos_q + 1'b1;
          state_d    = UP;
          reversal_d = (state_q == DOWN);
        end else if (delta == D_DOWN) begin
          step_dn_d  = 1'b1;
          pos_d      = pos_q - 1'b1;
          state_d    = DOWN;
          reversal_d = (state_q == UP);
        end
      end
    end

    // Clear wins over anything classified on this edge but leaves armed alone.
    if (bus.clear) begin
      armed_d    = armed_q;
      state_d    = IDLE;
      pos_d      = '0;
      step_up_d  = 1'b0;
      step_dn_d  = 1'b0;
      reversal_d = 1'b0;
      err_d      = 1'b0;
      err_cnt_d  = 4'd0;
    end
  end

  // State and registered outputs; reset forces everything to zero immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      pos_q      <= '0;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      reversal_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= 4'd0;
    end else begin
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      pos_q      <= pos_d;
      step_up_q  <= step_up_d;
      step_dn_q  <= step_dn_d;
      reversal_q <= reversal_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.pos      = pos_q;
  assign bus.step_up  = step_up_q;
  assign bus.step_dn  = step_dn_q;
  assign bus.reversal = reversal_q;
  assign bus.dir      = state_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_step_tracker.sv
// Directed self-checking bench for step_tracker (POS_W = 8).
module tb_step_tracker;

  localparam int POS_W = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [1:0] cur;

  step_tracker_if #(.POS_W(POS_W)) bus ();

  step_tracker #(.POS_W(POS_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one sample (plus clear) and wait until just after the capturing edge.
  task automatic tick(input logic [1:0] v, input logic clr);
    bus.A     = v[1];
    bus.B     = v[0];
    bus.clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int p, input int su, input int sd,
                         input int rv, input int d, input int e, input int ec);
    chk({tag, ".pos"},      bus.pos,      p);
    chk({tag, ".step_up"},  bus.step_up,  su);
    chk({tag, ".step_dn"},  bus.step_dn,  sd);
    chk({tag, ".reversal"}, bus.reversal, rv);
    chk({tag, ".dir"},      bus.dir,      d);
    chk({tag, ".err"},      bus.err,      e);
    chk({tag, ".err_cnt"},  bus.err_cnt,  ec);
    $display("step %s: pos=%0d up=%0b dn=%0b rev=%0b dir=%b err=%0b cnt=%0d",
             tag, bus.pos, bus.step_up, bus.step_dn, bus.reversal, bus.dir, bus.err, bus.err_cnt);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.A    = 1'b1;
    bus.B    = 1'b0;
    bus.clear = 1'b0;

    // Reset held over a few edges
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

    // Release reset; first edge with 10 only arms
    reset_n = 1'b1;
    tick(2'b10, 1'b0);
    chk_all("arm", 0, 0, 0, 0, 0, 0, 0);

    // 10 -> 11 -> 00 -> 01 : three up steps
    tick(2'b11, 1'b0);
    chk_all("up1", 1, 1, 0, 0, 1, 0, 0);
    tick(2'b00, 1'b0);
    chk_all("up2", 2, 1, 0, 0, 1, 0, 0);
    tick(2'b01, 1'b0);
    chk_all("up3", 3, 1, 0, 0, 1, 0, 0);

    // 01 -> 00 : down with reversal
    tick(2'b00, 1'b0);
    chk_all("rev_dn", 2, 0, 1, 1, 2, 0, 0);

    // Hold
    tick(2'b00, 1'b0);
    chk_all("hold", 2, 0, 0, 0, 2, 0, 0);

    // 00 -> 10 illegal
    tick(2'b10, 1'b0);
    chk_all("illegal", 2, 0, 0, 0, 3, 1, 1);

    // Legal up while in FAULT is ignored
    tick(2'b11, 1'b0);
    chk_all("fault_up", 2, 0, 0, 0, 3, 1, 1);

    // 17 illegal jumps from 11: 01,11,01,... err_cnt saturates at 15
    cur = 2'b11;
    for (int i = 0; i < 17; i++) begin
      cur = cur + 2'd2;
      tick(cur, 1'b0);
      chk("sat.err_cnt", bus.err_cnt, (i + 2 > 15) ? 15 : i + 2);
      chk("sat.pos", bus.pos, 2);
    end
    chk_all("sat", 2, 0, 0, 0, 3, 1, 15);

    // cur is 01; clear on the same edge as an up step (01 -> 10)
    tick(2'b10, 1'b1);
    chk_all("clear", 0, 0, 0, 0, 0, 0, 0);
    tick(2'b11, 1'b0);
    chk_all("post_clear_up", 1, 1, 0, 0, 1, 0, 0);

    // Clear with a hold to get pos back to 0, then 127 up steps
    tick(2'b11, 1'b1);
    chk_all("clear2", 0, 0, 0, 0, 0, 0, 0);
    cur = 2'b11;
    for (int i = 0; i < 127; i++) begin
      cur = cur + 2'd1;
      tick(cur, 1'b0);
    end
    chk_all("pos127", 127, 1, 0, 0, 1, 0, 0);
    cur = cur + 2'd1;
    tick(cur, 1'b0);
    chk_all("wrap_up", -128, 1, 0, 0, 1, 0, 0);
    cur = cur - 2'd1;
    tick(cur, 1'b0);
    chk_all("wrap_dn", 127, 0, 1, 1, 2, 0, 0);

    // Asynchronous reset pulse of 3 ns, between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b1;
    // prev is 00 after reset; 01 would be an up step but must only arm
    tick(2'b01, 1'b0);
    chk_all("rearm", 0, 0, 0, 0, 0, 0, 0);
    tick(2'b10, 1'b0);
    chk_all("after_rearm", 1, 1, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
